// File: rtl/parking_gate_arbiter.sv
// Barrier-gate arbiter: grants/refuses entry and exit requests against per-zone capacity,
// times the gate pulse and keeps the packed occupancy bus. Optional: PARKING_GATE_ARBITER_REFUSE_CNT_EN.
module parking_gate_arbiter #(
    parameter int unsigned GATE_CYC = 4,
    parameter int unsigned CAP      = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_req,
    input  logic [1:0]  entry_zone,
    input  logic        exit_req,
    input  logic [1:0]  exit_zone,
    output logic        entry_ack,
    output logic        entry_deny,
    output logic        exit_ack,
    output logic        exit_err,
    output logic        gate_open,
    output logic [11:0] s1a,
    output logic [4:0]  free_total,
    output logic        lot_full
`ifdef PARKING_GATE_ARBITER_REFUSE_CNT_EN
    ,
    output logic [7:0]  refuse_cnt
`endif
);

    localparam int unsigned GW      = $clog2(GATE_CYC + 1);
    localparam logic [2:0]  CapV    = 3'(CAP);
    localparam logic [4:0]  FreeMax = 5'(4 * CAP);

    typedef enum logic [1:0] {StIdle, StGate, StWaitRel} state_e;

    state_e          state_q, state_d;
    logic [3:0][2:0] cnt_q, cnt_d;
    logic            ptr_q, ptr_d;          // 0: entry has priority, 1: exit
    logic            win_exit_q, win_exit_d;
    logic [1:0]      win_zone_q, win_zone_d;
    logic [GW-1:0]   gate_cnt_q, gate_cnt_d;
    logic            gate_open_d;
    logic            entry_ack_d, entry_deny_d, exit_ack_d, exit_err_d;
    logic            use_exit;
    logic [1:0]      zone;
    logic [4:0]      occ_sum;

    assign use_exit = exit_req && (!entry_req || ptr_q);
    assign zone     = use_exit ? exit_zone : entry_zone;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        win_exit_d   = win_exit_q;
        win_zone_d   = win_zone_q;
        gate_cnt_d   = gate_cnt_q;
        gate_open_d  = gate_open;
        entry_ack_d  = 1'b0;
        entry_deny_d = 1'b0;
        exit_ack_d   = 1'b0;
        exit_err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (entry_req || exit_req) begin
                    win_exit_d = use_exit;
                    win_zone_d = zone;
                    ptr_d      = ~ptr_q;
                    if (!use_exit) begin
                        if (cnt_q[zone] < CapV) begin
                            cnt_d[zone] = cnt_q[zone] + 3'd1;
                            entry_ack_d = 1'b1;
                            gate_open_d = 1'b1;
                            gate_cnt_d  = GW'(GATE_CYC - 1);
                            state_d     = StGate;
                        end else begin
                            entry_deny_d = 1'b1;
                            state_d      = StWaitRel;
                        end
                    end else begin
                        if (cnt_q[zone] != 3'd0) begin
                            cnt_d[zone] = cnt_q[zone] - 3'd1;
                            exit_ack_d  = 1'b1;
                            gate_open_d = 1'b1;
                            gate_cnt_d  = GW'(GATE_CYC - 1);
                            state_d     = StGate;
                        end else begin
                            exit_err_d = 1'b1;
                            state_d    = StWaitRel;
                        end
                    end
                end
            end
            StGate: begin
                if (gate_cnt_q == '0) begin
                    gate_open_d = 1'b0;
                    state_d     = StWaitRel;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            StWaitRel: begin
                if (!(win_exit_q ? exit_req : entry_req)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= 1'b0;
            win_exit_q <= 1'b0;
            win_zone_q <= 2'd0;
            gate_cnt_q <= '0;
            gate_open  <= 1'b0;
            entry_ack  <= 1'b0;
            entry_deny <= 1'b0;
            exit_ack   <= 1'b0;
            exit_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            win_exit_q <= win_exit_d;
            win_zone_q <= win_zone_d;
            gate_cnt_q <= gate_cnt_d;
            gate_open  <= gate_open_d;
            entry_ack  <= entry_ack_d;
            entry_deny <= entry_deny_d;
            exit_ack   <= exit_ack_d;
            exit_err   <= exit_err_d;
        end
    end

`ifdef PARKING_GATE_ARBITER_REFUSE_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            refuse_cnt <= 8'd0;
        end else if ((entry_deny_d || exit_err_d) && refuse_cnt != 8'hFF) begin
            refuse_cnt <= refuse_cnt + 8'd1;
        end
    end
`endif

    always_comb begin
        occ_sum    = 5'(cnt_q[0]) + 5'(cnt_q[1]) + 5'(cnt_q[2]) + 5'(cnt_q[3]);
        free_total = FreeMax - occ_sum;
        lot_full   = (cnt_q[0] == CapV) && (cnt_q[1] == CapV) &&
                     (cnt_q[2] == CapV) && (cnt_q[3] == CapV);
        s1a        = cnt_q;
    end

endmodule
